// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage access unit: instruction classes, access size codes,
// FSM states and small decode helpers used by the top and the lane aligner.
package mem_access_unit_pkg;

  localparam logic [3:0] IR_LOAD  = 4'h3;
  localparam logic [3:0] IR_STORE = 4'h4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte accesses are always aligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane logic: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension. Kept separate for reuse by a cache.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rdata[{offset, 3'b000} +: 8];
  assign half_val = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b0000;
    wdata_out = 32'h0;
    load_data = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << offset;
        wdata_out = {4{wdata_in[7:0]}};
        load_data = funct3[2] ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
      end
      F3_H, F3_HU: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
        load_data = funct3[2] ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_out = wdata_in;
        load_data = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the EX/MEM load/store into one req/ack bus transaction,
// holds the pipeline interlock while it is in flight, and returns extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ir_type_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        flush_in,
  output logic        interlock,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        access_fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:2]      addr_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic             timeout_q;
  logic [31:0]      load_data_q;

  logic        mem_op;
  logic        legal;
  logic        aligned;
  logic        access_start;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign mem_op       = ((ir_type_in == IR_LOAD) || (ir_type_in == IR_STORE)) && !flush_in;
  assign legal        = f3_legal(funct3_in);
  assign aligned      = f3_aligned(funct3_in, addr_in[1:0]);
  assign access_start = mem_op && legal && aligned;

  // In BUSY the lane logic works from the registered request so load extraction
  // uses the size/offset of the access in flight, not whatever EX/MEM shows.
  assign sel_f3  = (state_q == ST_BUSY) ? f3_q  : funct3_in;
  assign sel_off = (state_q == ST_BUSY) ? off_q : addr_in[1:0];

  mem_lane_align u_lane (
    .funct3    (sel_f3),
    .offset    (sel_off),
    .wdata_in  (wdata_in),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .load_data (lane_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      timeout_q   <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (access_start) begin
            addr_q    <= addr_in[31:2];
            off_q     <= addr_in[1:0];
            f3_q      <= funct3_in;
            we_q      <= (ir_type_in == IR_STORE);
            be_q      <= lane_be;
            wdata_q   <= lane_wdata;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          // An ack on the terminal count still counts as success.
          if (mem_ack) begin
            if (!we_q) load_data_q <= lane_load;
          end else if (cnt_q == TERMINAL) begin
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // IDLE outputs are gated by rst_n so a held load cannot raise interlock during reset.
  always_comb begin
    state_d      = state_q;
    interlock    = 1'b0;
    mem_req      = 1'b0;
    misaligned   = 1'b0;
    access_fault = 1'b0;
    load_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && mem_op) begin
          if (!legal) begin
            access_fault = 1'b1;
          end else if (!aligned) begin
            misaligned = 1'b1;
          end else begin
            interlock = 1'b1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        mem_req   = 1'b1;
        interlock = 1'b1;
        if (mem_ack || (cnt_q == TERMINAL)) state_d = ST_DONE;
      end
      ST_DONE: begin
        access_fault = timeout_q;
        load_valid   = !timeout_q && !we_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q, 2'b00} : 32'h0;
  assign mem_be    = mem_req ? be_q : 4'b0000;
  assign mem_wdata = mem_req ? wdata_q : 32'h0;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses
// compared against a size/offset arithmetic model of the bus and load-extension rules.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ir_type_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        flush_in;
  logic        interlock;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        access_fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_load_data = 32'h0;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir_type_in   (ir_type_in),
    .funct3_in    (funct3_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .flush_in     (flush_in),
    .interlock    (interlock),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misaligned   (misaligned),
    .access_fault (access_fault)
  );

  always #5 clk = ~clk;

  // One access through IDLE/BUSY/DONE. ack_at = BUSY cycle carrying the ack; outside 1..T means never.
  task automatic run_access(input logic [3:0] ir, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                            input logic fl);
    bit is_mem, legal, aligned, start, is_load, success;
    int size, off, busy_n, req_cnt, ilk_cnt;
    logic [31:0] e_be, e_wd, mask, val;
    is_mem  = (ir == 4'h3) || (ir == 4'h4);
    is_load = (ir == 4'h3);
    legal   = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size    = 1 << f3[1:0];
    off     = addr % 4;
    aligned = legal && ((addr % size) == 0);
    start   = is_mem && !fl && legal && aligned;
    req_cnt = 0;
    ilk_cnt = 0;

    @(posedge clk); #1;
    ir_type_in = ir; funct3_in = f3; addr_in = addr; wdata_in = wd; flush_in = fl; mem_ack = 1'b0;
    @(negedge clk);
    n_checks += 5;
    if (interlock !== start) begin n_fail++; $display("[TB] FAIL idle_interlock: got %b want %b", interlock, start); end
    if (misaligned !== (is_mem && !fl && legal && !aligned)) begin n_fail++; $display("[TB] FAIL misaligned: got %b want %b", misaligned, is_mem && !fl && legal && !aligned); end
    if (access_fault !== (is_mem && !fl && !legal)) begin n_fail++; $display("[TB] FAIL illegal_fault: got %b want %b", access_fault, is_mem && !fl && !legal); end
    if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_req: got %b want 0", mem_req); end
    if (load_data !== exp_load_data) begin n_fail++; $display("[TB] FAIL idle_load_data: got %h want %h", load_data, exp_load_data); end
    if (!start) return;

    e_be    = (((32'd1 << size) - 32'd1) << off) & 32'hF;
    e_wd    = (size == 1) ? wd[7:0] * 32'h01010101 : (size == 2) ? wd[15:0] * 32'h00010001 : wd;
    success = (ack_at >= 1) && (ack_at <= T);
    busy_n  = success ? ack_at : T;
    for (int k = 1; k <= busy_n; k++) begin
      @(posedge clk); #1;
      mem_ack = (k == ack_at); mem_rdata = rd;
      @(negedge clk);
      if (mem_req) req_cnt++;
      if (interlock) ilk_cnt++;
      if (k == 1) begin
        n_checks += 3;
        if (mem_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("[TB] FAIL mem_addr: got %h want %h", mem_addr, {addr[31:2], 2'b00}); end
        if (mem_be !== e_be[3:0]) begin n_fail++; $display("[TB] FAIL mem_be: got %b want %b", mem_be, e_be[3:0]); end
        if (mem_we !== !is_load) begin n_fail++; $display("[TB] FAIL mem_we: got %b want %b", mem_we, !is_load); end
        if (!is_load) begin
          n_checks++;
          if (mem_wdata !== e_wd) begin n_fail++; $display("[TB] FAIL mem_wdata: got %h want %h", mem_wdata, e_wd); end
        end
      end
    end

    // DONE: a stray ack with junk data here must be ignored.
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    if (success && is_load) begin
      mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
      val  = (rd >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      exp_load_data = val;
    end
    n_checks += 7;
    if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL done_req: got %b want 0", mem_req); end
    if (interlock !== 1'b0) begin n_fail++; $display("[TB] FAIL done_interlock: got %b want 0", interlock); end
    if (load_valid !== (success && is_load)) begin n_fail++; $display("[TB] FAIL load_valid: got %b want %b", load_valid, success && is_load); end
    if (access_fault !== !success) begin n_fail++; $display("[TB] FAIL timeout_fault: got %b want %b", access_fault, !success); end
    if (load_data !== exp_load_data) begin n_fail++; $display("[TB] FAIL load_data: got %h want %h", load_data, exp_load_data); end
    if (req_cnt !== busy_n) begin n_fail++; $display("[TB] FAIL req_cycles: got %0d want %0d", req_cnt, busy_n); end
    if (ilk_cnt !== busy_n) begin n_fail++; $display("[TB] FAIL busy_interlock_cycles: got %0d want %0d", ilk_cnt, busy_n); end
  endtask

  task automatic set_nop();
    ir_type_in = 4'h0; funct3_in = 3'b000; addr_in = 32'h0; wdata_in = 32'h0; flush_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    ir_type_in = 4'h3; funct3_in = 3'b010; addr_in = 32'h100; wdata_in = 32'h0; flush_in = 1'b0;
    #12;
    n_checks += 5;
    if (interlock !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_interlock: got %b want 0", interlock); end
    if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b want 0", mem_req); end
    if (load_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_load_data: got %h want 0", load_data); end
    if (load_valid !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got %b%b want 00", load_valid, misaligned); end
    if (access_fault !== 1'b0 || mem_be !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_bus: got %b %b want 0 0000", access_fault, mem_be); end
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_access(4'h3, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0);
    run_access(4'h3, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 1'b0);
    run_access(4'h3, 3'b100, 32'h103, 32'h0, 32'h80112233, 3, 1'b0);
    run_access(4'h4, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1, 1'b0);
    run_access(4'h3, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1'b0);
    run_access(4'h3, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b0);
    run_access(4'h3, 3'b010, 32'h104, 32'h0, 32'h0, 1, 1'b1);
  endtask

  task automatic test_timeout();
    run_access(4'h3, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 1'b0);
    run_access(4'h3, 3'b101, 32'h302, 32'h0, 32'h9ABC1234, T, 1'b0);
  endtask

  task automatic test_ack_outside_busy();
    @(posedge clk); #1;
    set_nop(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (load_data !== exp_load_data) begin n_fail++; $display("[TB] FAIL idle_ack_load_data: got %h want %h", load_data, exp_load_data); end
    if (load_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ack_pulse: got %b%b want 00", load_valid, mem_req); end
  endtask

  task automatic test_reset_in_busy();
    @(posedge clk); #1;
    mem_ack = 1'b0;
    ir_type_in = 4'h3; funct3_in = 3'b010; addr_in = 32'h400; flush_in = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_req: got %b want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    exp_load_data = 32'h0;
    n_checks += 3;
    if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy_req: got %b want 0", mem_req); end
    if (interlock !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy_interlock: got %b want 0", interlock); end
    if (load_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_busy_load_data: got %h want 0", load_data); end
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] ir;
    logic [2:0] f3;
    logic [31:0] addr;
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ir  = (sel < 4) ? 4'h3 : (sel < 8) ? 4'h4 : (sel == 8) ? 4'h0 : 4'h5;
      f3  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : (($urandom_range(0, 1) == 1) ? 3'd2 : 3'($urandom_range(0, 1)) | (3'($urandom_range(0, 1)) << 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = (f3[1:0] == 2'd2) ? 2'b00 : (f3[1:0] == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
      run_access(ir, f3, addr, $urandom, $urandom, $urandom_range(1, T + 1), ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_back_to_back();
    run_access(4'h3, 3'b001, 32'h500, 32'h0, 32'h0000F00F, 1, 1'b0);
    run_access(4'h4, 3'b000, 32'h501, 32'h000000A5, 32'h0, 2, 1'b0);
    run_access(4'h3, 3'b000, 32'h502, 32'h0, 32'h00770000, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ack_outside_busy();
    test_back_to_back();
    test_reset_in_busy();
    test_random();
    test_ack_outside_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
